// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl
//   Reset sequencer between the reset synchronizer and the Knight's Tour
//   sub-blocks. All stage resets are held low for HOLD_CYC cycles. Stages are
//   then released one at a time in index order. Each release waits for that
//   stage's ready, then GAP_CYC idle cycles, before the next stage is released.
//   Once every stage is up, a dropped ready, or a stage that never comes ready,
//   latches a fault that holds all stages in reset. Soft re-sequence requests
//   are arbitrated round-robin. They are honoured only once sequencing has
//   settled, in DONE or FAULT.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        async active-low reset (from the reset synchronizer)
//   soft_req     [NUM_REQ]     level re-sequence requests, held until granted
//   soft_gnt     [NUM_REQ]     one-hot single-cycle grant pulse
//   stage_rdy    [NUM_STAGES]  per-stage "initialized" status
//   stage_rst_n  [NUM_STAGES]  per-stage active-low reset (registered)
//   seq_done     all stages released and healthy
//   seq_err      sticky fault flag, cleared only by a soft grant or rst_n
//   err_stage    index of the stage that faulted
module reset_seq_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_REQ    = 2,
    parameter int HOLD_CYC   = 16,
    parameter int GAP_CYC    = 8,
    parameter int TMO_CYC    = 1024,
    localparam int IW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int MAXC      = (HOLD_CYC > GAP_CYC)
                               ? ((HOLD_CYC > TMO_CYC) ? HOLD_CYC : TMO_CYC)
                               : ((GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC),
    localparam int CW        = $clog2(MAXC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    soft_req,
    output logic [NUM_REQ-1:0]    soft_gnt,
    input  logic [NUM_STAGES-1:0] stage_rdy,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [IW-1:0]         err_stage
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_RDY,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                state, nxt_state;
    logic [IW-1:0]         idx, nxt_idx;
    logic [CW-1:0]         cnt, nxt_cnt;
    logic [PW-1:0]         ptr, nxt_ptr;
    logic [NUM_STAGES-1:0] nxt_stage_rst_n;
    logic [NUM_REQ-1:0]    nxt_soft_gnt;
    logic                  nxt_seq_done;
    logic                  nxt_seq_err;
    logic [IW-1:0]         nxt_err_stage;

    // Round-robin arbiter: first asserted request at or after ptr, wrapping.
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt_vec;

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && soft_req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    // Lowest released stage whose ready has dropped. The loop scans downward
    // so that the last assignment, and therefore the result, is the lowest index.
    logic          drop_any;
    logic [IW-1:0] drop_idx;

    always_comb begin
        drop_any = 1'b0;
        drop_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_rst_n[i] && !stage_rdy[i]) begin
                drop_any = 1'b1;
                drop_idx = IW'(i);
            end
        end
    end

    // State and all outputs are registered together, so no input reaches
    // an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HOLD;
            idx         <= '0;
            cnt         <= '0;
            ptr         <= '0;
            stage_rst_n <= '0;
            soft_gnt    <= '0;
            seq_done    <= 1'b0;
            seq_err     <= 1'b0;
            err_stage   <= '0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            ptr         <= nxt_ptr;
            stage_rst_n <= nxt_stage_rst_n;
            soft_gnt    <= nxt_soft_gnt;
            seq_done    <= nxt_seq_done;
            seq_err     <= nxt_seq_err;
            err_stage   <= nxt_err_stage;
        end
    end

    always_comb begin
        nxt_state       = state;
        nxt_idx         = idx;
        nxt_cnt         = cnt;
        nxt_ptr         = ptr;
        nxt_stage_rst_n = stage_rst_n;
        nxt_soft_gnt    = '0;
        nxt_seq_done    = seq_done;
        nxt_seq_err     = seq_err;
        nxt_err_stage   = err_stage;

        case (state)
            S_HOLD: begin
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    nxt_state = S_RELEASE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_RELEASE: begin
                nxt_stage_rst_n[idx] = 1'b1;
                nxt_cnt              = '0;
                nxt_state            = S_WAIT_RDY;
            end

            S_WAIT_RDY: begin
                // A ready seen on the timeout cycle still counts as success.
                if (stage_rdy[idx]) begin
                    nxt_cnt = '0;
                    if (idx == IW'(NUM_STAGES - 1)) begin
                        nxt_state    = S_DONE;
                        nxt_seq_done = 1'b1;
                    end else begin
                        nxt_state = S_GAP;
                    end
                end else if (cnt == CW'(TMO_CYC - 1)) begin
                    nxt_state       = S_FAULT;
                    nxt_seq_err     = 1'b1;
                    nxt_err_stage   = idx;
                    nxt_stage_rst_n = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    nxt_state = S_RELEASE;
                    nxt_idx   = idx + IW'(1);
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end

            S_DONE: begin
                // A grant takes priority: the re-sequence resets every stage
                // anyway, so a coincident ready drop needs no fault.
                if (gnt_any) begin
                    nxt_state = S_HOLD;
                end else if (drop_any) begin
                    nxt_state       = S_FAULT;
                    nxt_seq_err     = 1'b1;
                    nxt_err_stage   = drop_idx;
                    nxt_seq_done    = 1'b0;
                    nxt_stage_rst_n = '0;
                end
            end

            S_FAULT: begin
                nxt_stage_rst_n = '0;
                if (gnt_any) nxt_state = S_HOLD;
            end

            default: begin
                nxt_state       = S_FAULT;
                nxt_stage_rst_n = '0;
            end
        endcase

        // Grant: restart the whole sequence from HOLD. err_stage keeps the
        // last fault index for post-mortem reads.
        if ((state == S_DONE || state == S_FAULT) && gnt_any) begin
            nxt_soft_gnt    = gnt_vec;
            nxt_stage_rst_n = '0;
            nxt_seq_done    = 1'b0;
            nxt_seq_err     = 1'b0;
            nxt_idx         = '0;
            nxt_cnt         = '0;
            nxt_ptr         = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
module tb_reset_seq_ctrl;

    localparam int NS   = 3;
    localparam int NR   = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int TMO  = 1024;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] soft_req;
    logic [NR-1:0] soft_gnt;
    logic [NS-1:0] stage_rdy;
    logic [NS-1:0] stage_rst_n;
    logic          seq_done;
    logic          seq_err;
    logic [1:0]    err_stage;

    int errors = 0;
    int checks = 0;
    int edges;

    reset_seq_ctrl #(
        .NUM_STAGES(NS), .NUM_REQ(NR), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_req(soft_req), .soft_gnt(soft_gnt),
        .stage_rdy(stage_rdy), .stage_rst_n(stage_rst_n), .seq_done(seq_done),
        .seq_err(seq_err), .err_stage(err_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last rst_n release; edge 1 is the first one.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Advance to the falling edge following rising edge n.
    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (edges < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edges != n) check("run_to", edges, n);
    endtask

    task automatic do_reset(input logic [NS-1:0] rdy);
        @(negedge clk);
        rst_n     = 1'b0;
        soft_req  = '0;
        stage_rdy = rdy;
        #1;
        check("rst_stage_rst_n", stage_rst_n, 0);
        check("rst_soft_gnt", soft_gnt, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_err_stage", err_stage, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model. It keeps timestamps of scheduled events rather than
    // counters: it records when the next release is due and when the
    // current stage was released. Each step represents one rising edge,
    // with the inputs that are sampled at that edge.
    localparam int MD_REL = 0, MD_RDY = 1, MD_DONE = 2, MD_FAULT = 3;
    int            mt, m_mode, m_k, m_rel_at, m_rel_edge, m_ptr;
    logic [NS-1:0] e_rst;
    logic [NR-1:0] e_gnt;
    logic          e_done, e_err;
    logic [1:0]    e_estg;

    task automatic model_reset();
        mt = 0; m_mode = MD_REL; m_k = 0; m_rel_at = HOLD + 1; m_rel_edge = 0; m_ptr = 0;
        e_rst = '0; e_gnt = '0; e_done = 1'b0; e_err = 1'b0; e_estg = '0;
    endtask

    task automatic model_fault(input int k);
        e_rst = '0; e_err = 1'b1; e_estg = 2'(k); e_done = 1'b0; m_mode = MD_FAULT;
    endtask

    task automatic model_step(input logic [NR-1:0] req, input logic [NS-1:0] rdy);
        int g, low;
        g = -1; low = -1;
        mt++;
        e_gnt = '0;
        if (m_mode == MD_DONE || m_mode == MD_FAULT)
            for (int k = 0; k < NR; k++)
                if (g < 0 && req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g >= 0) begin
            e_gnt[g] = 1'b1;
            m_ptr    = (g + 1) % NR;
            e_rst    = '0; e_done = 1'b0; e_err = 1'b0;
            m_k      = 0; m_rel_at = mt + HOLD + 1; m_mode = MD_REL;
        end else if (m_mode == MD_REL) begin
            if (mt == m_rel_at) begin
                e_rst[m_k] = 1'b1; m_rel_edge = mt; m_mode = MD_RDY;
            end
        end else if (m_mode == MD_RDY) begin
            if (rdy[m_k]) begin
                if (m_k == NS - 1) begin
                    m_mode = MD_DONE; e_done = 1'b1;
                end else begin
                    m_k++; m_rel_at = mt + GAP + 1; m_mode = MD_REL;
                end
            end else if (mt - m_rel_edge == TMO) begin
                model_fault(m_k);
            end
        end else if (m_mode == MD_DONE) begin
            for (int i = NS - 1; i >= 0; i--) if (!rdy[i]) low = i;
            if (low >= 0) model_fault(low);
        end
    endtask

    typedef struct {
        int            edge_n;
        logic [NS-1:0] rst;
        logic          done;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NR-1:0] r_req;
        logic [NS-1:0] cur_rdy;
        int            hold_cnt;
        int            b;

        tbl[0] = '{1,  3'b000, 1'b0};
        tbl[1] = '{16, 3'b000, 1'b0};
        tbl[2] = '{17, 3'b001, 1'b0};
        tbl[3] = '{26, 3'b001, 1'b0};
        tbl[4] = '{27, 3'b011, 1'b0};
        tbl[5] = '{36, 3'b011, 1'b0};
        tbl[6] = '{37, 3'b111, 1'b0};
        tbl[7] = '{38, 3'b111, 1'b1};
        tbl[8] = '{45, 3'b111, 1'b1};
        tbl[9] = '{60, 3'b111, 1'b1};

        rst_n = 1'b0; soft_req = '0; stage_rdy = '0;

        // Nominal power-up sequence with every stage ready at once.
        do_reset(3'b111);
        for (int i = 0; i < 10; i++) begin
            run_to(tbl[i].edge_n);
            check($sformatf("t1_rst_e%0d", tbl[i].edge_n), stage_rst_n, tbl[i].rst);
            check($sformatf("t1_done_e%0d", tbl[i].edge_n), seq_done, tbl[i].done);
            check($sformatf("t1_err_e%0d", tbl[i].edge_n), seq_err, 0);
        end

        // rst_n asserted in the middle of GAP takes effect without a clock edge.
        do_reset(3'b111);
        run_to(30);
        rst_n = 1'b0;
        #1;
        check("t5_async_rst", stage_rst_n, 0);
        check("t5_async_done", seq_done, 0);
        check("t5_async_err", seq_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_to(16);
        check("t5_e16", stage_rst_n, 3'b000);
        run_to(17);
        check("t5_e17", stage_rst_n, 3'b001);

        // A request raised during HOLD stays pending until DONE.
        do_reset(3'b111);
        run_to(5);
        soft_req = 2'b01;
        run_to(20);
        check("t4_gnt_e20", soft_gnt, 0);
        run_to(38);
        check("t4_gnt_e38", soft_gnt, 0);
        check("t4_done_e38", seq_done, 1);
        run_to(39);
        check("t4_gnt_e39", soft_gnt, 2'b01);
        soft_req = 2'b00;
        run_to(40);
        check("t4_gnt_e40", soft_gnt, 0);

        // Round-robin between two requests held continuously.
        do_reset(3'b111);
        run_to(38);
        soft_req = 2'b11;
        run_to(39);
        check("t3_gnt1", soft_gnt, 2'b01);
        check("t3_rst_drop", stage_rst_n, 0);
        check("t3_done_drop", seq_done, 0);
        run_to(40);
        check("t3_gnt1_pulse", soft_gnt, 0);
        run_to(55);
        check("t3_rerun_e55", stage_rst_n, 3'b000);
        run_to(56);
        check("t3_rerun_e56", stage_rst_n, 3'b001);
        run_to(77);
        check("t3_done2", seq_done, 1);
        check("t3_gnt_e77", soft_gnt, 0);
        run_to(78);
        check("t3_gnt2", soft_gnt, 2'b10);
        soft_req = 2'b00;
        run_to(117);
        check("t3_done3", seq_done, 1);
        check("t3_gnt_e117", soft_gnt, 0);

        // Stage 1 never ready: timeout fault. Then recovery, and a fault from a ready drop in DONE.
        do_reset(3'b101);
        run_to(27 + TMO - 1);
        check("t2_pre_err", seq_err, 0);
        check("t2_pre_rst", stage_rst_n, 3'b011);
        run_to(27 + TMO);
        check("t2_err", seq_err, 1);
        check("t2_estg", err_stage, 1);
        check("t2_rst", stage_rst_n, 3'b000);
        check("t2_done", seq_done, 0);
        run_to(27 + TMO + 9);
        check("t2_stay_err", seq_err, 1);
        check("t2_stay_rst", stage_rst_n, 0);
        stage_rdy = 3'b111;
        soft_req  = 2'b01;
        b = 27 + TMO + 10;
        run_to(b);
        check("t6_fgnt", soft_gnt, 2'b01);
        check("t6_fgnt_err", seq_err, 0);
        check("t6_fgnt_estg", err_stage, 1);
        soft_req = 2'b00;
        run_to(b + 38);
        check("t6_done", seq_done, 1);
        stage_rdy = 3'b110;
        run_to(b + 39);
        stage_rdy = 3'b111;
        check("t6_err", seq_err, 1);
        check("t6_estg", err_stage, 0);
        check("t6_rst", stage_rst_n, 0);
        check("t6_done0", seq_done, 0);
        run_to(b + 44);
        check("t6_stay", seq_err, 1);
        soft_req = 2'b10;
        run_to(b + 45);
        check("t6_gnt", soft_gnt, 2'b10);
        check("t6_gnt_err", seq_err, 0);
        soft_req = 2'b00;
        run_to(b + 45 + 17);
        check("t6_rerun", stage_rst_n, 3'b001);
        run_to(b + 45 + 38);
        check("t6_redone", seq_done, 1);

        // Random requests and ready glitches compared with the model each cycle.
        do_reset(3'b111);
        model_reset();
        r_req = '0; cur_rdy = 3'b111; hold_cnt = 0;
        for (int i = 0; i < 4000 && errors < 20; i++) begin
            r_req = r_req & ~e_gnt;
            for (int q = 0; q < NR; q++)
                if ($urandom_range(0, 39) == 0) r_req[q] = 1'b1;
            if (hold_cnt > 0) hold_cnt--;
            else if ($urandom_range(0, 99) < 6) begin
                cur_rdy  = NS'($urandom_range(0, 7));
                hold_cnt = $urandom_range(0, 4);
            end else cur_rdy = 3'b111;
            soft_req  = r_req;
            stage_rdy = cur_rdy;
            model_step(r_req, cur_rdy);
            @(negedge clk);
            check($sformatf("rnd_c%0d", i),
                  {stage_rst_n, soft_gnt, seq_done, seq_err, err_stage},
                  {e_rst, e_gnt, e_done, e_err, e_estg});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
